// File: rtl/bcd_radix_converter_if.sv
// -----------------------------------------------------------------------------
// bcd_radix_converter_if
// Request/result bundle for the sequential BCD-to-binary converter.
//   Start       : conversion request (level, acted on only while idle)
//   Mode        : 0 = hex digits, 1 = octal digits, captured with Start
//   bcd_in      : DIGITS packed BCD digits, ones digit in [3:0]
//   busy        : conversion in progress
//   done        : one-cycle pulse when the result registers update
//   invalid     : last accepted bcd_in held a nibble > 9
//   bin_out     : binary result
//   digit_out   : OD formatted digit nibbles, least significant in [3:0]
//   digit_blank : leading-zero flags per digit, bit 0 never set
// master = requester (display path / bench), slave = converter core.
// -----------------------------------------------------------------------------
interface bcd_radix_converter_if #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10,
   parameter int OD     = (BIN_W + 2) / 3
);
   logic                  Start;
   logic                  Mode;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic                  invalid;
   logic [BIN_W-1:0]      bin_out;
   logic [4*OD-1:0]       digit_out;
   logic [OD-1:0]         digit_blank;

   modport master (
      output Start, Mode, bcd_in,
      input  busy, done, invalid, bin_out, digit_out, digit_blank
   );

   modport slave (
      input  Start, Mode, bcd_in,
      output busy, done, invalid, bin_out, digit_out, digit_blank
   );
endinterface

// File: rtl/bcd_radix_converter.sv
// -----------------------------------------------------------------------------
// bcd_radix_converter
// Sequential N-digit BCD to binary converter (reverse double-dabble, one bit
// per cycle) with hex/octal digit formatting and leading-zero blanking.
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : bcd_radix_converter_if.slave (Start/Mode/bcd_in in,
//         busy/done/invalid/bin_out/digit_out/digit_blank out)
// Latency: BIN_W+2 cycles from accepted Start to done, 2 for invalid input.
// -----------------------------------------------------------------------------
module bcd_radix_converter #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input logic                  clk,
   input logic                  rst,
   bcd_radix_converter_if.slave bus
);
   localparam int OD = (BIN_W + 2) / 3;   // octal needs the most digits
   localparam int HD = (BIN_W + 3) / 4;
   localparam int BW = 4 * DIGITS;
   localparam int EW = 4 * OD;
   localparam int CW = $clog2(BIN_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_CONV  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [OD-1:0] BLANK_RST = ~OD'(1);

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   if (DIGITS < 1 || DIGITS > 6 || (longint'(1) << BIN_W) < pow10(DIGITS)) begin : g_param_check
      $error("bcd_radix_converter: BIN_W cannot hold 10**DIGITS-1 or DIGITS out of range");
   end

   function automatic logic any_bad(input logic [BW-1:0] b);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   // Undo the x2 of double-dabble: after a right shift a nibble >= 8 has
   // received a carry of 8 that should only have been 5.
   function automatic logic [BW-1:0] dabble_fix(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++)
         if (r[4*i +: 4] >= 4'd8) r[4*i +: 4] = r[4*i +: 4] - 4'd3;
      return r;
   endfunction

   function automatic logic [EW-1:0] fmt_digits(input logic [BIN_W-1:0] v, input logic oct);
      logic [EW-1:0] ext;
      logic [EW-1:0] r;
      ext = EW'(v);
      r   = '0;
      for (int k = 0; k < OD; k++) begin
         if (oct)         r[4*k +: 4] = {1'b0, ext[3*k +: 3]};
         else if (k < HD) r[4*k +: 4] = ext[4*k +: 4];
      end
      return r;
   endfunction

   function automatic logic [OD-1:0] fmt_blank(input logic [EW-1:0] d);
      logic [OD-1:0] r;
      logic          seen;
      r    = '0;
      seen = 1'b0;
      for (int k = OD - 1; k >= 1; k--) begin
         seen = seen | (d[4*k +: 4] != 4'd0);
         r[k] = ~seen;
      end
      return r;
   endfunction

   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic                err_q;
   logic                mode_q;
   logic [BW-1:0]       bcd_q;
   logic [BIN_W-1:0]    bin_q;

   logic                accept;
   logic [BW+BIN_W-1:0] shifted;
   logic [BW-1:0]       bcd_nx;
   logic [BIN_W-1:0]    bin_nx;
   logic [EW-1:0]       fmt_d;
   logic [OD-1:0]       fmt_b;

   always_comb begin
      accept  = (state == S_IDLE) && bus.Start;
      shifted = {bcd_q, bin_q} >> 1;
      bcd_nx  = dabble_fix(shifted[BW+BIN_W-1:BIN_W]);
      bin_nx  = shifted[BIN_W-1:0];
      fmt_d   = fmt_digits(bin_q, mode_q);
      fmt_b   = fmt_blank(fmt_d);
   end

   // Control and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= '0;
         err_q           <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.invalid     <= 1'b0;
         bus.bin_out     <= '0;
         bus.digit_out   <= '0;
         bus.digit_blank <= BLANK_RST;
      end else begin
         bus.done <= 1'b0;
         // busy is registered so it stays high through the cycle done is shown
         bus.busy <= accept || (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (bus.Start) begin
                  cnt   <= CW'(BIN_W);
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               err_q <= any_bad(bcd_q);
               state <= any_bad(bcd_q) ? S_DONE : S_CONV;
            end
            S_CONV: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= S_DONE;
            end
            default: begin
               bus.done <= 1'b1;
               state    <= S_IDLE;
               if (err_q) begin
                  bus.invalid     <= 1'b1;
                  bus.bin_out     <= '0;
                  bus.digit_out   <= '0;
                  bus.digit_blank <= BLANK_RST;
               end else begin
                  bus.invalid     <= 1'b0;
                  bus.bin_out     <= bin_q;
                  bus.digit_out   <= fmt_d;
                  bus.digit_blank <= fmt_b;
               end
            end
         endcase
      end
   end

   // Conversion datapath
   always_ff @(posedge clk) begin
      if (accept) begin
         bcd_q  <= bus.bcd_in;
         mode_q <= bus.Mode;
         bin_q  <= '0;
      end else if (state == S_CONV) begin
         bcd_q <= bcd_nx;
         bin_q <= bin_nx;
      end
   end
endmodule

// File: tb/tb_bcd_radix_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_radix_converter
// Directed checks of the converter at default parameters (DIGITS=3, BIN_W=10)
// and at DIGITS=4, BIN_W=14, plus a full 0..999 sweep in both modes.
// -----------------------------------------------------------------------------
module tb_bcd_radix_converter;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bcd_radix_converter_if #(.DIGITS(3), .BIN_W(10)) b3 ();
   bcd_radix_converter_if #(.DIGITS(4), .BIN_W(14)) b4 ();

   bcd_radix_converter #(.DIGITS(3), .BIN_W(10)) u3 (.clk(clk), .rst(rst), .bus(b3));
   bcd_radix_converter #(.DIGITS(4), .BIN_W(14)) u4 (.clk(clk), .rst(rst), .bus(b4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse Start for one cycle; lat = edges after the accepting edge until done.
   task automatic run3(input logic [11:0] bcd, input logic m, output int lat, output logic bsy);
      @(negedge clk);
      b3.bcd_in = bcd; b3.Mode = m; b3.Start = 1'b1;
      @(posedge clk); #1;
      b3.Start = 1'b0;
      lat = 0;
      while (!b3.done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      bsy = b3.busy;
   endtask

   task automatic run4(input logic [15:0] bcd, input logic m, output int lat);
      @(negedge clk);
      b4.bcd_in = bcd; b4.Mode = m; b4.Start = 1'b1;
      @(posedge clk); #1;
      b4.Start = 1'b0;
      lat = 0;
      while (!b4.done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   function automatic logic [15:0] ref_digits(input int v, input logic m);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < 4; k++)
         r[4*k +: 4] = m ? 4'((v >> (3*k)) & 7) : 4'((v >> (4*k)) & 15);
      return r;
   endfunction

   function automatic logic [3:0] ref_blank(input logic [15:0] d);
      logic [3:0] r;
      logic       seen;
      r    = '0;
      seen = 1'b0;
      for (int k = 3; k >= 1; k--) begin
         seen = seen | (d[4*k +: 4] != 4'd0);
         r[k] = ~seen;
      end
      return r;
   endfunction

   initial begin
      int          lat;
      logic        bsy;
      int          ndone;
      int          first_edge;
      int          second_edge;
      logic [11:0] bcd;
      logic [15:0] d;

      rst = 1'b1;
      b3.Start = 1'b0; b3.Mode = 1'b0; b3.bcd_in = '0;
      b4.Start = 1'b0; b4.Mode = 1'b0; b4.bcd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  b3.busy, 0);
      chk("rst_done",  b3.done, 0);
      chk("rst_inv",   b3.invalid, 0);
      chk("rst_bin",   b3.bin_out, 0);
      chk("rst_dig",   b3.digit_out, 0);
      chk("rst_blank", b3.digit_blank, 4'b1110);
      rst = 1'b0;

      // 999 hex and octal
      run3(12'h999, 1'b0, lat, bsy);
      chk("999h_lat",   lat, 12);
      chk("999h_busy",  bsy, 1);
      chk("999h_bin",   b3.bin_out, 999);
      chk("999h_dig",   b3.digit_out, 16'h03E7);
      chk("999h_blank", b3.digit_blank, 4'b1000);
      chk("999h_inv",   b3.invalid, 0);
      run3(12'h999, 1'b1, lat, bsy);
      chk("999o_dig",   b3.digit_out, 16'h1747);
      chk("999o_blank", b3.digit_blank, 4'b0000);

      // zero, then invalid digit
      run3(12'h000, 1'b0, lat, bsy);
      chk("0_bin",   b3.bin_out, 0);
      chk("0_dig",   b3.digit_out, 0);
      chk("0_blank", b3.digit_blank, 4'b1110);
      run3(12'h0A5, 1'b0, lat, bsy);
      chk("inv_lat",   lat, 2);
      chk("inv_flag",  b3.invalid, 1);
      chk("inv_bin",   b3.bin_out, 0);
      chk("inv_dig",   b3.digit_out, 0);
      chk("inv_blank", b3.digit_blank, 4'b1110);

      // input change and Start re-pulse during CONV are ignored
      @(negedge clk);
      b3.bcd_in = 12'h123; b3.Mode = 1'b0; b3.Start = 1'b1;
      @(posedge clk); #1;
      b3.Start = 1'b0;
      ndone = 0;
      repeat (3) begin @(posedge clk); #1; if (b3.done) ndone++; end
      @(negedge clk);
      b3.bcd_in = 12'h456; b3.Start = 1'b1;
      @(posedge clk); #1;
      b3.Start = 1'b0;
      if (b3.done) ndone++;
      repeat (25) begin @(posedge clk); #1; if (b3.done) ndone++; end
      chk("inflt_ndone", ndone, 1);
      chk("inflt_bin",   b3.bin_out, 123);
      chk("inflt_dig",   b3.digit_out, 16'h007B);
      chk("inflt_inv",   b3.invalid, 0);

      // reset mid-CONV
      @(negedge clk);
      b3.bcd_in = 12'h456; b3.Start = 1'b1;
      @(posedge clk); #1;
      b3.Start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy",  b3.busy, 0);
      chk("abort_done",  b3.done, 0);
      chk("abort_bin",   b3.bin_out, 0);
      chk("abort_dig",   b3.digit_out, 0);
      chk("abort_blank", b3.digit_blank, 4'b1110);
      rst = 1'b0;
      ndone = 0;
      repeat (20) begin @(posedge clk); #1; if (b3.done) ndone++; end
      chk("abort_ndone", ndone, 0);

      // Start held high: back-to-back throughput
      @(negedge clk);
      b3.bcd_in = 12'h999; b3.Mode = 1'b0; b3.Start = 1'b1;
      first_edge = -1; second_edge = -1;
      for (int e = 0; e < 40 && second_edge < 0; e++) begin
         @(posedge clk); #1;
         if (b3.done) begin
            if (first_edge < 0) first_edge = e;
            else                second_edge = e;
         end
      end
      b3.Start = 1'b0;
      chk("b2b_first",  first_edge, 12);
      chk("b2b_period", second_edge - first_edge, 13);
      repeat (20) @(posedge clk);

      // wider instance
      run4(16'h9999, 1'b0, lat);
      chk("w_lat",   lat, 16);
      chk("w_bin",   b4.bin_out, 9999);
      chk("w_dig",   b4.digit_out, 20'h0270F);
      chk("w_blank", b4.digit_blank, 5'b10000);
      run4(16'h9999, 1'b1, lat);
      chk("w_oct",   b4.digit_out, 20'h23417);
      chk("w_oblnk", b4.digit_blank, 5'b00000);

      // full sweep in both modes
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < 1000; v++) begin
            bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run3(bcd, m[0], lat, bsy);
            d = ref_digits(v, m[0]);
            chk("sw_bin",   b3.bin_out, 64'(v));
            chk("sw_dig",   b3.digit_out, d);
            chk("sw_blank", b3.digit_blank, ref_blank(d));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
